dual_imu_packet_formatter: RTL and testbench

//  Downstream of the dual BNO085 controller. On data_ready, snapshots both sensors'

---
 rtl/imu_pkt_pkg.sv | 17 +
 rtl/dual_imu_packet_formatter.sv | 200 ++++++++++++++++++++
 tb/tb_dual_imu_packet_formatter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_pkt_pkg.sv
// Shared constants and types for the dual-IMU packet formatter.
package imu_pkt_pkg;

  localparam int PKT_LEN   = 33;
  localparam int CHK_IDX   = 32;
  localparam int NUM_WORDS = 14;

  localparam int FLAG_S1V  = 0;
  localparam int FLAG_S2V  = 1;
  localparam int FLAG_INIT = 2;
  localparam int FLAG_ERR  = 3;

  typedef enum logic [1:0] {IDLE, SEND, GAP} fmt_state_t;

  typedef logic signed [15:0] imu_word_t;

endpackage

// File: rtl/dual_imu_packet_formatter.sv
// Snapshots both IMUs on data_ready and streams a 33-byte checksummed packet
// bytewise over valid/ready; all outputs are registered.
//
// state | meaning
// IDLE  | waiting for enable && data_ready
// SEND  | presenting byte[idx], advancing on each accept
// GAP   | forced m_valid=0 spacing after the checksum byte
module dual_imu_packet_formatter
  import imu_pkt_pkg::*;
#(
  parameter logic [7:0]  HDR0        = 8'hAA,
  parameter logic [7:0]  HDR1        = 8'h55,
  parameter int unsigned MIN_GAP_CYC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               data_ready,
  input  logic               sensor1_valid,
  input  logic               sensor2_valid,
  input  logic               initialized,
  input  logic               error,
  input  logic signed [15:0] quat1_w,
  input  logic signed [15:0] quat1_x,
  input  logic signed [15:0] quat1_y,
  input  logic signed [15:0] quat1_z,
  input  logic signed [15:0] gyro1_x,
  input  logic signed [15:0] gyro1_y,
  input  logic signed [15:0] gyro1_z,
  input  logic signed [15:0] quat2_w,
  input  logic signed [15:0] quat2_x,
  input  logic signed [15:0] quat2_y,
  input  logic signed [15:0] quat2_z,
  input  logic signed [15:0] gyro2_x,
  input  logic signed [15:0] gyro2_y,
  input  logic signed [15:0] gyro2_z,
  output logic               consume,
  output logic               m_valid,
  output logic [7:0]         m_data,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic [7:0]         seq
);

  localparam logic [5:0]  CHK_IDX6 = 6'(CHK_IDX);
  localparam logic [15:0] GAP_LOAD = (MIN_GAP_CYC > 0) ? 16'(MIN_GAP_CYC - 1) : 16'd0;

  fmt_state_t  state_q, state_d;
  imu_word_t   snap_q  [NUM_WORDS];
  imu_word_t   snap_in [NUM_WORDS];
  logic [3:0]  flags_q, flags_in;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] gap_q, gap_d;
  logic        consume_q, consume_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, busy_d;
  logic        start, accept, last_acc;

  function automatic logic [7:0] pick_byte(input logic [5:0] idx,
                                           input imu_word_t  snap [NUM_WORDS],
                                           input logic [3:0] flags,
                                           input logic [7:0] sq,
                                           input logic [7:0] cs);
    logic [4:0] off;
    logic [7:0] b;
    off = 5'(idx - 6'd4);
    case (idx)
      6'd0:     b = HDR0;
      6'd1:     b = HDR1;
      6'd2:     b = sq;
      6'd3:     b = {4'b0000, flags};
      CHK_IDX6: b = cs;
      default:  b = off[0] ? snap[off[4:1]][7:0] : snap[off[4:1]][15:8];
    endcase
    return b;
  endfunction

  always_comb begin
    snap_in[0]  = quat1_w;
    snap_in[1]  = quat1_x;
    snap_in[2]  = quat1_y;
    snap_in[3]  = quat1_z;
    snap_in[4]  = gyro1_x;
    snap_in[5]  = gyro1_y;
    snap_in[6]  = gyro1_z;
    snap_in[7]  = quat2_w;
    snap_in[8]  = quat2_x;
    snap_in[9]  = quat2_y;
    snap_in[10] = quat2_z;
    snap_in[11] = gyro2_x;
    snap_in[12] = gyro2_y;
    snap_in[13] = gyro2_z;
    flags_in            = '0;
    flags_in[FLAG_S1V]  = sensor1_valid;
    flags_in[FLAG_S2V]  = sensor2_valid;
    flags_in[FLAG_INIT] = initialized;
    flags_in[FLAG_ERR]  = error;
  end

  // The last GAP cycle may start a packet directly, so the gap is exactly MIN_GAP_CYC.
  assign start    = enable && data_ready &&
                    ((state_q == IDLE) || ((state_q == GAP) && (gap_q == '0)));
  assign accept   = m_valid_q && m_ready;
  assign last_acc = (state_q == SEND) && accept && (idx_q == CHK_IDX6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (last_acc) state_d = (MIN_GAP_CYC > 0) ? GAP : IDLE;
      GAP:     if (gap_q == '0) state_d = start ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    consume_d = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    if (start) begin
      consume_d = 1'b1;
      m_valid_d = 1'b1;
      m_data_d  = HDR0;
      m_last_d  = 1'b0;
      idx_d     = '0;
      csum_d    = '0;
    end else if (last_acc) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_data_d  = '0;
      seq_d     = seq_q + 8'd1;
      gap_d     = GAP_LOAD;
    end else if ((state_q == SEND) && accept) begin
      idx_d = idx_q + 6'd1;
      if (idx_q >= 6'd2) csum_d = csum_q + m_data_q;
      m_data_d = pick_byte(idx_d, snap_q, flags_q, seq_q, csum_d);
      m_last_d = (idx_d == CHK_IDX6);
    end else if ((state_q == GAP) && (gap_q != '0)) begin
      gap_d = gap_q - 16'd1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consume_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      csum_q    <= '0;
      seq_q     <= '0;
      gap_q     <= '0;
    end else begin
      consume_q <= consume_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      seq_q     <= seq_d;
      gap_q     <= gap_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) snap_q[i] <= '0;
      flags_q <= '0;
    end else if (start) begin
      snap_q  <= snap_in;
      flags_q <= flags_in;
    end
  end

  assign consume = consume_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign seq     = seq_q;

endmodule

// File: tb/tb_dual_imu_packet_formatter.sv
// Directed bench for dual_imu_packet_formatter: a byte scoreboard fed by a
// packet model, plus a second instance with a forced inter-packet gap.
module tb_dual_imu_packet_formatter;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, data_ready, m_ready;
  logic enable_g, data_ready_g, m_ready_g;
  logic s1v, s2v, init_f, err_f;
  logic signed [15:0] w [14];

  logic       consume, m_valid, m_last, busy;
  logic [7:0] m_data, seq;
  logic       consume_g, m_valid_g, m_last_g, busy_g;
  logic [7:0] m_data_g, seq_g;

  logic [7:0] exp_q [$];
  logic [7:0] exp_seq;
  int n_vec, n_err;

  always #5 clk = ~clk;

  dual_imu_packet_formatter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_ready(data_ready),
    .sensor1_valid(s1v), .sensor2_valid(s2v), .initialized(init_f), .error(err_f),
    .quat1_w(w[0]), .quat1_x(w[1]), .quat1_y(w[2]), .quat1_z(w[3]),
    .gyro1_x(w[4]), .gyro1_y(w[5]), .gyro1_z(w[6]),
    .quat2_w(w[7]), .quat2_x(w[8]), .quat2_y(w[9]), .quat2_z(w[10]),
    .gyro2_x(w[11]), .gyro2_y(w[12]), .gyro2_z(w[13]),
    .consume(consume), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .seq(seq)
  );

  dual_imu_packet_formatter #(.MIN_GAP_CYC(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .enable(enable_g), .data_ready(data_ready_g),
    .sensor1_valid(s1v), .sensor2_valid(s2v), .initialized(init_f), .error(err_f),
    .quat1_w(w[0]), .quat1_x(w[1]), .quat1_y(w[2]), .quat1_z(w[3]),
    .gyro1_x(w[4]), .gyro1_y(w[5]), .gyro1_z(w[6]),
    .quat2_w(w[7]), .quat2_x(w[8]), .quat2_y(w[9]), .quat2_z(w[10]),
    .gyro2_x(w[11]), .gyro2_y(w[12]), .gyro2_z(w[13]),
    .consume(consume_g), .m_valid(m_valid_g), .m_data(m_data_g), .m_last(m_last_g),
    .m_ready(m_ready_g), .busy(busy_g), .seq(seq_g)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packet built from the current bench inputs.
  task automatic push_pkt(input logic [7:0] s);
    logic [7:0] b [33];
    logic [7:0] sum;
    b[0] = 8'hAA;
    b[1] = 8'h55;
    b[2] = s;
    b[3] = {4'b0000, err_f, init_f, s2v, s1v};
    for (int i = 0; i < 14; i++) begin
      b[4 + 2*i] = w[i][15:8];
      b[5 + 2*i] = w[i][7:0];
    end
    sum = 8'h00;
    for (int i = 2; i < 32; i++) sum = sum + b[i];
    b[32] = sum;
    for (int i = 0; i < 33; i++) exp_q.push_back(b[i]);
  endtask

  // mode 0: always ready, 1: ready toggles. act 1: inputs to FFFF at idx 10,
  // act 2: reset at idx 15, act 3: enable low at idx 5.
  task automatic recv(input int mode, input int act, input bit drop_dr,
                      output int acc, output int cons, output logic [7:0] lastb);
    logic [7:0] held, e;
    bit stalled;
    int cyc;
    acc = 0; cons = 0; stalled = 0; cyc = 0; held = 8'h00; lastb = 8'h00;
    while (acc < 33) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        chk("recv_timeout", acc, 33);
        return;
      end
      if (consume) begin
        cons++;
        if (drop_dr) data_ready = 1'b0;
      end
      if (act == 1 && acc == 10) begin
        for (int i = 0; i < 14; i++) w[i] = 16'hFFFF;
        s1v = 1'b1; s2v = 1'b1; init_f = 1'b1; err_f = 1'b1;
      end
      if (act == 3 && acc == 5) enable = 1'b0;
      if (act == 2 && acc == 15) begin
        rst_n = 1'b0;
        #1;
        chk("t5_abort_m_valid", m_valid, 0);
        chk("t5_abort_m_last", m_last, 0);
        chk("t5_abort_m_data", m_data, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_seq", seq, 0);
        exp_q.delete();
        return;
      end
      if (stalled) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_data", m_data, held);
        chk("stall_m_last", m_last, (acc == 32));
      end
      m_ready = (mode == 0) ? 1'b1 : cyc[0];
      if (m_valid && m_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk($sformatf("byte%0d", acc), m_data, e);
        chk($sformatf("last%0d", acc), m_last, (acc == 32));
        if (acc == 32) lastb = m_data;
        acc++;
        stalled = 0;
      end else begin
        stalled = m_valid;
        held = m_data;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic after_pkt(input string tag);
    @(negedge clk);
    exp_seq = exp_seq + 8'd1;
    chk(tag, seq, exp_seq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cons, cyc, gapc, cnt;
    bit found;
    logic [7:0] lastb;
    n_vec = 0; n_err = 0; exp_seq = 8'h00;
    rst_n = 1'b0; enable = 1'b0; data_ready = 1'b0; m_ready = 1'b1;
    enable_g = 1'b0; data_ready_g = 1'b0; m_ready_g = 1'b1;
    s1v = 1'b0; s2v = 1'b0; init_f = 1'b0; err_f = 1'b0;
    for (int i = 0; i < 14; i++) w[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_consume", consume, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq", seq, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single packet, always ready
    w[0] = 16'h0102; s1v = 1'b1; s2v = 1'b1; init_f = 1'b1; err_f = 1'b0;
    enable = 1'b1; data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(0, 0, 1, acc, cons, lastb);
    chk("t1_consume_pulses", cons, 1);
    chk("t1_chk_byte", lastb, 8'h0A);
    after_pkt("t1_seq");
    chk("t1_idle_m_valid", m_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Test 2: same inputs, ready toggling
    data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(1, 0, 1, acc, cons, lastb);
    chk("t2_accepts", acc, 33);
    chk("t2_consume_pulses", cons, 1);
    after_pkt("t2_seq");

    // Test 3: snapshot isolation
    for (int i = 0; i < 14; i++) w[i] = 16'(16'h1000 + i * 16'h0123);
    s1v = 1'b1; s2v = 1'b0; init_f = 1'b1; err_f = 1'b0;
    data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(0, 1, 1, acc, cons, lastb);
    after_pkt("t3_seq_a");
    data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(0, 0, 1, acc, cons, lastb);
    chk("t3_consume_pulses", cons, 1);
    after_pkt("t3_seq_b");

    // Test 4: 257 back-to-back packets, seq wraps
    exp_seq = seq;
    w[3] = 16'h5A3C; w[9] = 16'h8001;
    data_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      push_pkt(exp_seq);
      recv(0, 0, 0, acc, cons, lastb);
      chk("t4_consume_pulses", cons, 1);
      if (k == 256) data_ready = 1'b0;
      after_pkt("t4_seq");
    end

    // Test 5: reset mid-packet, then fresh packet
    for (int i = 0; i < 14; i++) w[i] = 16'h0000;
    w[0] = 16'h0102; s1v = 1'b1; s2v = 1'b1; init_f = 1'b1; err_f = 1'b0;
    data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(0, 2, 1, acc, cons, lastb);
    repeat (2) @(negedge clk);
    data_ready = 1'b1;
    rst_n = 1'b1;
    exp_seq = 8'h00;
    push_pkt(exp_seq);
    recv(0, 0, 1, acc, cons, lastb);
    chk("t5_consume_pulses", cons, 1);
    chk("t5_chk_byte", lastb, 8'h0A);
    after_pkt("t5_seq");

    // enable falls mid-packet: packet completes, nothing new starts
    data_ready = 1'b1;
    push_pkt(exp_seq);
    recv(0, 3, 0, acc, cons, lastb);
    after_pkt("ten_seq");
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (consume || m_valid) cnt++;
    end
    chk("ten_no_start", cnt, 0);
    chk("ten_seq_hold", seq, exp_seq);
    data_ready = 1'b0;

    // Test 6: forced gap of 4 on the second instance
    enable_g = 1'b1; data_ready_g = 1'b1; m_ready_g = 1'b1;
    cyc = 0; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk); cyc++;
      if (m_valid_g && m_last_g && m_ready_g) found = 1;
    end
    chk("t6_first_last_seen", found, 1);
    gapc = 0; cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (!m_valid_g) gapc++;
    end while (!m_valid_g && cyc < 50);
    chk("t6_gap_cycles", gapc, 4);
    chk("t6_hdr0", m_data_g, 8'hAA);
    chk("t6_consume", consume_g, 1);
    chk("t6_seq_after_first", seq_g, 1);
    enable_g = 1'b0;
    cyc = 0; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk); cyc++;
      if (m_valid_g && m_last_g && m_ready_g) found = 1;
    end
    chk("t6_second_last_seen", found, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (consume_g || m_valid_g) cnt++;
    end
    chk("t6_disabled_no_start", cnt, 0);
    chk("t6_seq_after_second", seq_g, 2);
    chk("t6_busy_idle", busy_g, 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
